// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit layout and helpers.
// Imported by id_ex_stage and load_use_detect.
package pipe_pkg;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LO  = 5;
    localparam int CTRL_ALU_OP_HI  = 7;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [7:0] CTRL_BUBBLE = '0;

    // Saturating increment for 16-bit event counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the EX-stage load
// and the instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;
    logic ex_load;

    assign ex_load  = ex_valid & ex_mem_read & (ex_rd != REG_AW'(REG_ZERO));
    assign rs_hit   = id_uses_rs & (id_rs == ex_rd);
    assign rt_hit   = id_uses_rt & (id_rt == ex_rd);
    assign load_use = ex_load & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional hazard counters enabled by defining HAZARD_STATS_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_reg_a,
    input  logic [DATA_W-1:0] id_reg_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_reg_a,
    output logic [DATA_W-1:0] ex_reg_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_front,
    output logic [15:0]       load_use_cnt,
    output logic [15:0]       flush_cnt
);

    logic load_use;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_ctrl[CTRL_MEM_READ]),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .load_use   (load_use)
    );

    // A taken flush redirects the front end, so it must not also stall it
    assign stall_front = ~flush & (ex_hold | load_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_reg_a <= '0;
            ex_reg_b <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else if (flush || (!ex_hold && load_use)) begin
            // Bubble: zero rd/ctrl kills forwarding and writes; data is don't-care
            ex_valid <= 1'b0;
            ex_rd    <= REG_AW'(REG_ZERO);
            ex_ctrl  <= CTRL_W'(CTRL_BUBBLE);
        end else if (!ex_hold) begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_reg_a <= id_reg_a;
            ex_reg_b <= id_reg_b;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_W'(CTRL_BUBBLE);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] lu_q;
    logic [15:0] fl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_q <= '0;
            fl_q <= '0;
        end else begin
            if (flush)
                fl_q <= sat_inc(fl_q);
            if (!flush && !ex_hold && load_use)
                lu_q <= sat_inc(lu_q);
        end
    end

    assign load_use_cnt = lu_q;
    assign flush_cnt    = fl_q;
`else
    assign load_use_cnt = 16'd0;
    assign flush_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected results,
// monitor pops and compares each cycle.
module tb_id_ex_stage;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  id_rd = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_reg_a = '0;
    logic [31:0] id_reg_b = '0;
    logic [31:0] id_imm = '0;
    logic [7:0]  id_ctrl = '0;
    logic        flush = 1'b0;
    logic        ex_hold = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_reg_a;
    logic [31:0] ex_reg_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;
    logic        stall_front;
    logic [15:0] load_use_cnt;
    logic [15:0] flush_cnt;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic [31:0] a;
        logic [15:0] lu;
        logic [15:0] fl;
    } exp_t;

    exp_t sb[$];

    id_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_reg_a    (id_reg_a),
        .id_reg_b    (id_reg_b),
        .id_imm      (id_imm),
        .id_ctrl     (id_ctrl),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_reg_a    (ex_reg_a),
        .ex_reg_b    (ex_reg_b),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_ctrl     (ex_ctrl),
        .stall_front (stall_front),
        .load_use_cnt(load_use_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one ID beat at the falling edge and queue what must follow
    task automatic step(
        input string nm,
        input bit v, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input bit urs, input bit urt,
        input logic [7:0] ctrl, input logic [31:0] a,
        input bit fl, input bit hd,
        input bit e_stall, input bit e_valid, input logic [4:0] e_rd,
        input logic [7:0] e_ctrl, input logic [31:0] e_a,
        input logic [15:0] e_lu, input logic [15:0] e_fl);
        exp_t e;
        @(negedge clk);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_ctrl    = ctrl;
        id_reg_a   = a;
        id_reg_b   = ~a;
        id_imm     = a + 32'd1;
        id_pc      = a << 2;
        flush      = fl;
        ex_hold    = hd;
        e.name  = nm;
        e.stall = e_stall;
        e.valid = e_valid;
        e.rd    = e_rd;
        e.ctrl  = e_ctrl;
        e.a     = e_a;
        e.lu    = STATS ? e_lu : 16'd0;
        e.fl    = STATS ? e_fl : 16'd0;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".stall"}, 32'(stall_front), 32'(e.stall));
                @(posedge clk);
                #1;
                chk({e.name, ".valid"}, 32'(ex_valid), 32'(e.valid));
                chk({e.name, ".rd"}, 32'(ex_rd), 32'(e.rd));
                chk({e.name, ".ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
                chk({e.name, ".reg_a"}, ex_reg_a, e.a);
                chk({e.name, ".reg_b"}, ex_reg_b, ~e.a);
                chk({e.name, ".imm"}, ex_imm, e.a + 32'd1);
                chk({e.name, ".pc"}, ex_pc, e.a << 2);
                chk({e.name, ".lu_cnt"}, 32'(load_use_cnt), 32'(e.lu));
                chk({e.name, ".fl_cnt"}, 32'(flush_cnt), 32'(e.fl));
            end
        end
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        chk("reset.valid", 32'(ex_valid), 32'd0);
        chk("reset.ctrl", 32'(ex_ctrl), 32'd0);
        rst_n = 1'b1;

        //   name        v  rs  rt  rd urs urt ctrl   a     fl hd | st v rd ctrl  a     lu fl
        step("pass",     1, 3,  4,  5, 1, 1, 8'h01, 32'h11, 0, 0,  0, 1, 5, 8'h01, 32'h11, 0, 0);

        // Asynchronous reset mid-cycle with a live instruction in EX
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(ex_valid), 32'd0);
        chk("async_rst.rd", 32'(ex_rd), 32'd0);
        chk("async_rst.ctrl", 32'(ex_ctrl), 32'd0);
        chk("async_rst.reg_a", ex_reg_a, 32'd0);
        chk("async_rst.pc", ex_pc, 32'd0);
        chk("async_rst.rs", 32'(ex_rs), 32'd0);
        #2;
        rst_n = 1'b1;

        step("pass2",    1, 3,  4,  5, 1, 1, 8'h01, 32'h11, 0, 0,  0, 1, 5, 8'h01, 32'h11, 0, 0);
        step("lw_r8",    1, 1,  8,  8, 1, 0, 8'h1B, 32'h20, 0, 0,  0, 1, 8, 8'h1B, 32'h20, 0, 0);
        step("lu_stall", 1, 8,  2,  9, 1, 1, 8'h01, 32'h30, 0, 0,  1, 0, 0, 8'h00, 32'h20, 1, 0);
        step("add_in",   1, 8,  2,  9, 1, 1, 8'h01, 32'h30, 0, 0,  0, 1, 9, 8'h01, 32'h30, 1, 0);
        step("lw_r0",    1, 0,  0,  0, 1, 1, 8'h1B, 32'h40, 0, 0,  0, 1, 0, 8'h1B, 32'h40, 1, 0);
        step("r0_use",   1, 0,  0,  7, 1, 1, 8'h01, 32'h50, 0, 0,  0, 1, 7, 8'h01, 32'h50, 1, 0);
        step("lw_r8b",   1, 1,  8,  8, 1, 0, 8'h1B, 32'h60, 0, 0,  0, 1, 8, 8'h1B, 32'h60, 1, 0);
        step("rt_unused",1, 2,  8, 10, 1, 0, 8'h01, 32'h70, 0, 0,  0, 1,10, 8'h01, 32'h70, 1, 0);
        step("lw_r8c",   1, 1,  8,  8, 1, 0, 8'h1B, 32'h80, 0, 0,  0, 1, 8, 8'h1B, 32'h80, 1, 0);
        step("collide",  1, 8,  2, 11, 1, 1, 8'h01, 32'h90, 1, 1,  0, 0, 0, 8'h00, 32'h80, 1, 1);
        step("lw_r8d",   1, 1,  3,  8, 1, 0, 8'h1B, 32'hA0, 0, 0,  0, 1, 8, 8'h1B, 32'hA0, 1, 1);
        step("rt_stall", 1, 2,  8, 12, 0, 1, 8'h01, 32'hB0, 0, 0,  1, 0, 0, 8'h00, 32'hA0, 2, 1);
        step("rt_in",    1, 2,  8, 12, 0, 1, 8'h01, 32'hB0, 0, 0,  0, 1,12, 8'h01, 32'hB0, 2, 1);
        step("hold1",    1, 1,  2, 13, 1, 1, 8'h01, 32'hC0, 0, 1,  1, 1,12, 8'h01, 32'hB0, 2, 1);
        step("hold2",    1, 1,  2, 14, 1, 1, 8'h05, 32'hC1, 0, 1,  1, 1,12, 8'h01, 32'hB0, 2, 1);
        step("hold3",    1, 1,  2, 15, 1, 1, 8'h09, 32'hC2, 0, 1,  1, 1,12, 8'h01, 32'hB0, 2, 1);
        step("release",  1, 1,  2, 16, 1, 1, 8'h11, 32'hC3, 0, 0,  0, 1,16, 8'h11, 32'hC3, 2, 1);
        step("id_inval", 0, 4,  5, 17, 1, 1, 8'hFF, 32'hD0, 0, 0,  0, 0,17, 8'h00, 32'hD0, 2, 1);

        // Drive many flushes to reach counter saturation
        @(negedge clk);
        flush = 1'b1;
        repeat (65540) @(negedge clk);
        step("sat",      1, 4,  5, 18, 1, 1, 8'h01, 32'hE0, 1, 0,  0, 0, 0, 8'h00, 32'hD0, 2, 16'hFFFF);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
